mem_port_arbiter: RTL and testbench

- Shares one MemoryController request port between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Sequences each access as one transaction: arbitrate, issue a one-cycle read/write strobe, wait on mcStatus, return data/ack.
- Round-robin grant with a timeout watchdog. Sits between the CPU front-end and the MemoryController instance.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 31 +++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter.
//   - Widths of the address/data paths to the MemoryController.
//   - mcStatus encodings driven by the MemoryController.
//   - Arbiter FSM state type and state constants.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // mcStatus encodings
  localparam logic [1:0] MC_IDLE  = 2'd0;
  localparam logic [1:0] MC_BUSY  = 2'd1;
  localparam logic [1:0] MC_DONE  = 2'd2;
  localparam logic [1:0] MC_FAULT = 2'd3;

  // Arbiter FSM states
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t StIdle  = 2'd0;
  localparam arb_state_t StIssue = 2'd1;
  localparam arb_state_t StWait  = 2'd2;
  localparam arb_state_t StResp  = 2'd3;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : request vector, bit n = port n
//   accept_i     : grant is taken this cycle; the last-grant pointer moves to it
//   valid_o      : at least one request is present
//   grant_o      : index of the granted port (combinational)
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       valid_o,
  output logic       grant_o
);

  logic last_q;

  assign valid_o = |req_i;
  // On a tie the port that was not served last wins; otherwise the lone requester.
  assign grant_o = (req_i == 2'b11) ? ~last_q : req_i[1];

  // Reset to 1 so that port 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (accept_i) begin
      last_q <= grant_o;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one MemoryController request port between port 0 (fetch) and port 1 (load/store).
// Each access runs IDLE -> ISSUE (one-cycle strobe) -> WAIT (poll mcStatus, watchdog) -> RESP
// (one-cycle ack to the granted port).
//   clk, reset            : clock, asynchronous active-high reset
//   p{0,1}Req/Write/...   : requester inputs, sampled only in IDLE
//   p{0,1}Ack/RData/Fault : completion pulse, registered read data and fault flag
//   execMode              : latched at grant and driven on mcExecMode
//   mc*                   : registered request to the MemoryController
//   RamOutput, mcStatus   : response from the MemoryController
//   busy                  : a transaction is in progress
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0Req,
  input  logic              p0Write,
  input  logic [ADDR_W-1:0] p0Addr,
  input  logic [DATA_W-1:0] p0WData,
  input  logic              p0Virtual,
  output logic              p0Ack,
  output logic [DATA_W-1:0] p0RData,
  output logic              p0Fault,
  input  logic              p1Req,
  input  logic              p1Write,
  input  logic [ADDR_W-1:0] p1Addr,
  input  logic [DATA_W-1:0] p1WData,
  input  logic              p1Virtual,
  output logic              p1Ack,
  output logic [DATA_W-1:0] p1RData,
  output logic              p1Fault,
  input  logic              execMode,
  output logic [ADDR_W-1:0] mcRamAddress,
  output logic [DATA_W-1:0] mcRamIn,
  output logic              mcReadReq,
  output logic              mcWriteReq,
  output logic              mcAddrVirtual,
  output logic              mcExecMode,
  input  logic [DATA_W-1:0] RamOutput,
  input  logic [1:0]        mcStatus,
  output logic              busy
);

  arb_state_t              state_q, state_d;
  logic                    grant_q, grant_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic                    virt_q, virt_d;
  logic                    exec_q, exec_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]              fault_q, fault_d;

  logic arb_valid, arb_grant, arb_accept;

  rr_arbiter2 u_rr (
    .clk_i    (clk),
    .rst_i    (reset),
    .req_i    ({p1Req, p0Req}),
    .accept_i (arb_accept),
    .valid_o  (arb_valid),
    .grant_o  (arb_grant)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    to_cnt_d   = to_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    virt_d     = virt_q;
    exec_d     = exec_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    arb_accept = 1'b0;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          arb_accept = 1'b1;
          grant_d    = arb_grant;
          addr_d     = arb_grant ? p1Addr    : p0Addr;
          wdata_d    = arb_grant ? p1WData   : p0WData;
          write_d    = arb_grant ? p1Write   : p0Write;
          virt_d     = arb_grant ? p1Virtual : p0Virtual;
          exec_d     = execMode;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        to_cnt_d = '0;
        state_d  = StWait;
      end
      StWait: begin
        // Completion beats fault, which beats the watchdog.
        if (mcStatus == MC_DONE) begin
          rdata_d[grant_q] = RamOutput;
          fault_d[grant_q] = 1'b0;
          state_d          = StResp;
        end else if ((mcStatus == MC_FAULT) || (to_cnt_q == TO_W'(TIMEOUT_CYCLES))) begin
          rdata_d[grant_q] = '0;
          fault_d[grant_q] = 1'b1;
          state_d          = StResp;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      to_cnt_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      virt_q   <= 1'b0;
      exec_q   <= 1'b0;
      rdata_q  <= '0;
      fault_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      to_cnt_q <= to_cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      virt_q   <= virt_d;
      exec_q   <= exec_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  assign mcRamAddress  = addr_q;
  assign mcRamIn       = wdata_q;
  assign mcAddrVirtual = virt_q;
  assign mcExecMode    = exec_q;
  assign mcReadReq     = (state_q == StIssue) && !write_q;
  assign mcWriteReq    = (state_q == StIssue) && write_q;
  assign p0Ack         = (state_q == StResp) && !grant_q;
  assign p1Ack         = (state_q == StResp) && grant_q;
  assign p0RData       = rdata_q[0];
  assign p1RData       = rdata_q[1];
  assign p0Fault       = fault_q[0];
  assign p1Fault       = fault_q[1];
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transactions, a bench-side MemoryController responder
// with a byte RAM, a transaction-level model checked every cycle, and literal expectations.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0Req, p0Write, p0Virtual, p1Req, p1Write, p1Virtual, execMode;
  logic [31:0] p0Addr, p0WData, p1Addr, p1WData;
  logic        p0Ack, p0Fault, p1Ack, p1Fault;
  logic [31:0] p0RData, p1RData;
  logic [31:0] mcRamAddress, mcRamIn, RamOutput;
  logic        mcReadReq, mcWriteReq, mcAddrVirtual, mcExecMode, busy;
  logic [1:0]  mcStatus;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .p0Req(p0Req), .p0Write(p0Write), .p0Addr(p0Addr), .p0WData(p0WData),
    .p0Virtual(p0Virtual), .p0Ack(p0Ack), .p0RData(p0RData), .p0Fault(p0Fault),
    .p1Req(p1Req), .p1Write(p1Write), .p1Addr(p1Addr), .p1WData(p1WData),
    .p1Virtual(p1Virtual), .p1Ack(p1Ack), .p1RData(p1RData), .p1Fault(p1Fault),
    .execMode(execMode), .mcRamAddress(mcRamAddress), .mcRamIn(mcRamIn),
    .mcReadReq(mcReadReq), .mcWriteReq(mcWriteReq), .mcAddrVirtual(mcAddrVirtual),
    .mcExecMode(mcExecMode), .RamOutput(RamOutput), .mcStatus(mcStatus), .busy(busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------- MemoryController responder ----------------
  logic [7:0] ram [256];
  int         resp_delay = 2;
  logic [1:0] resp_status = MC_DONE;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    int b;
    b = int'(a[7:0]);
    return {ram[(b + 3) & 255], ram[(b + 2) & 255], ram[(b + 1) & 255], ram[b]};
  endfunction

  task automatic respond();
    mcStatus  = resp_status;
    RamOutput = (resp_status == MC_DONE) ? ram_word(mcRamAddress) : 32'hBAD0_BAD0;
  endtask

  initial begin
    int rcnt;
    bit rclr;
    int b;
    rcnt = 0;
    rclr = 0;
    mcStatus = MC_IDLE;
    RamOutput = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[16] = 8'hEF; ram[17] = 8'hBE; ram[18] = 8'hAD; ram[19] = 8'hDE;
    forever begin
      @(negedge clk);
      if (reset) begin
        mcStatus = MC_IDLE;
        rcnt = 0;
        rclr = 0;
      end else begin
        if (rclr) begin
          mcStatus = MC_IDLE;
          rclr = 0;
        end
        if (mcReadReq || mcWriteReq) begin
          if (mcWriteReq) begin
            b = int'(mcRamAddress[7:0]);
            for (int k = 0; k < 4; k++) ram[(b + k) & 255] = mcRamIn[8*k +: 8];
          end
          if (resp_delay == 0) begin
            respond();
            rclr = (resp_status != MC_BUSY);
          end else begin
            mcStatus = MC_BUSY;
            rcnt = resp_delay;
          end
        end else if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin
            respond();
            rclr = (resp_status != MC_BUSY);
          end
        end
      end
    end
  end

  // ---------------- Transaction-level model + monitor ----------------
  // m_age counts cycles since the grant: 0 = strobe cycle, 1.. = waiting cycles.
  bit          m_act, m_resp, m_write, m_virt, m_exec;
  int          m_port, m_last, m_age;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata [2];
  bit          m_fault [2];

  int cyc = 0;
  int strobe_cnt = 0, strobe_cyc = 0, last_ack_cyc = 0;
  int ack_cnt [2];
  int glog [$];

  task automatic m_reset();
    m_act = 0; m_resp = 0; m_age = 0; m_port = 0; m_last = 1;
    m_write = 0; m_virt = 0; m_exec = 0; m_addr = '0; m_wdata = '0;
    m_rdata[0] = '0; m_rdata[1] = '0; m_fault[0] = 0; m_fault[1] = 0;
  endtask

  task automatic m_step();
    if (m_resp) begin
      m_resp = 0;
      m_act  = 0;
    end else if (m_act) begin
      if (m_age >= 1) begin
        if (mcStatus == MC_DONE) begin
          m_rdata[m_port] = RamOutput; m_fault[m_port] = 0; m_resp = 1;
        end else if (mcStatus == MC_FAULT || (m_age - 1) == int'(TO)) begin
          m_rdata[m_port] = '0; m_fault[m_port] = 1; m_resp = 1;
        end
      end
      m_age++;
    end else if (p0Req || p1Req) begin
      if (p0Req && p1Req) m_port = 1 - m_last;
      else m_port = p1Req ? 1 : 0;
      m_last  = m_port;
      m_addr  = m_port ? p1Addr : p0Addr;
      m_wdata = m_port ? p1WData : p0WData;
      m_write = m_port ? p1Write : p0Write;
      m_virt  = m_port ? p1Virtual : p0Virtual;
      m_exec  = execMode;
      m_act   = 1;
      m_age   = 0;
    end
  endtask

  task automatic m_compare();
    chk("busy", busy, m_act);
    chk("mcReadReq", mcReadReq, m_act && m_age == 0 && !m_write);
    chk("mcWriteReq", mcWriteReq, m_act && m_age == 0 && m_write);
    chk("p0Ack", p0Ack, m_resp && m_port == 0);
    chk("p1Ack", p1Ack, m_resp && m_port == 1);
    chk("mcRamAddress", mcRamAddress, m_addr);
    chk("mcRamIn", mcRamIn, m_wdata);
    chk("mcAddrVirtual", mcAddrVirtual, m_virt);
    chk("mcExecMode", mcExecMode, m_exec);
    chk("p0RData", p0RData, m_rdata[0]);
    chk("p1RData", p1RData, m_rdata[1]);
    chk("p0Fault", p0Fault, m_fault[0]);
    chk("p1Fault", p1Fault, m_fault[1]);
  endtask

  initial begin
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    m_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_reset();
      end else begin
        #1;
        if (!reset) begin
          m_step();
          m_compare();
          if (p0Ack) begin ack_cnt[0]++; glog.push_back(0); last_ack_cyc = cyc; end
          if (p1Ack) begin ack_cnt[1]++; glog.push_back(1); last_ack_cyc = cyc; end
          if (mcReadReq || mcWriteReq) begin strobe_cnt++; strobe_cyc = cyc; end
          cyc++;
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic wait_ack(input int port, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((port == 0 && p0Ack) || (port == 1 && p1Ack)) seen = 1;
    end
    chk($sformatf("ack_p%0d_seen", port), seen, 1);
    if (port == 0) p0Req = 0; else p1Req = 0;
  endtask

  task automatic wait_strobe(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (mcReadReq || mcWriteReq) seen = 1;
    end
    chk("strobe_seen", seen, 1);
  endtask

  initial begin
    int sb, a1b, gb;
    int order [4];
    bit seen;
    order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1;
    reset = 1;
    p0Req = 0; p0Write = 0; p0Addr = '0; p0WData = '0; p0Virtual = 0;
    p1Req = 0; p1Write = 0; p1Addr = '0; p1WData = '0; p1Virtual = 0;
    execMode = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_addr", mcRamAddress, 0);
    chk("rst_p0Ack", p0Ack, 0);
    repeat (2) @(negedge clk);
    reset = 0;

    // Port 0 read of 0x10, done after 3 cycles
    resp_delay = 3; resp_status = MC_DONE;
    sb = strobe_cnt; a1b = ack_cnt[1];
    @(negedge clk);
    p0Req = 1; p0Write = 0; p0Addr = 32'h10; p0Virtual = 1; execMode = 1;
    wait_ack(0, 20);
    chk("t1_rdata", p0RData, 32'hDEAD_BEEF);
    chk("t1_fault", p0Fault, 0);
    chk("t1_strobes", strobe_cnt - sb, 1);
    chk("t1_latency", last_ack_cyc - strobe_cyc, 4);
    chk("t1_p1_acks", ack_cnt[1] - a1b, 0);

    // Port 1 write of 0x123 to 0x0
    resp_delay = 2; execMode = 0;
    sb = strobe_cnt;
    @(negedge clk);
    p1Req = 1; p1Write = 1; p1Addr = 32'h0; p1WData = 32'h123; p1Virtual = 0;
    wait_ack(1, 20);
    chk("t2_fault", p1Fault, 0);
    chk("t2_strobes", strobe_cnt - sb, 1);
    chk("t2_ram", {ram[0], ram[1], ram[2], ram[3]}, 32'h2301_0000);
    p1Write = 0;

    // Both ports contend for four transactions: grants alternate 0,1,0,1
    gb = glog.size();
    @(negedge clk);
    p0Req = 1; p1Req = 1;
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (p0Ack || p1Ack) seen = 1;
      end
      chk("t3_ack_seen", seen, 1);
      if (p0Ack) p0Req = 0;
      if (p1Ack) p1Req = 0;
      if (k < 3) begin
        @(negedge clk);
        p0Req = 1; p1Req = 1;
      end
    end
    p0Req = 0; p1Req = 0;
    chk("t3_count", glog.size() - gb, 4);
    for (int k = 0; k < 4; k++)
      if (gb + k < glog.size()) chk($sformatf("t3_grant%0d", k), glog[gb + k], order[k]);

    // Fault status from the controller
    resp_delay = 2; resp_status = MC_FAULT;
    @(negedge clk);
    p0Req = 1; p0Addr = 32'h20;
    wait_ack(0, 20);
    chk("t4_fault", p0Fault, 1);
    chk("t4_rdata", p0RData, 0);

    // Status stuck busy: watchdog fires after TO+1 waiting cycles
    resp_delay = 1; resp_status = MC_BUSY;
    @(negedge clk);
    p1Req = 1; p1Addr = 32'h0;
    wait_ack(1, 40);
    chk("t5_fault", p1Fault, 1);
    chk("t5_rdata", p1RData, 0);
    chk("t5_latency", last_ack_cyc - strobe_cyc, TO + 2);

    // Done shown only in the strobe cycle is ignored, so this also times out
    resp_delay = 0; resp_status = MC_DONE;
    @(negedge clk);
    p0Req = 1; p0Addr = 32'h10;
    wait_ack(0, 40);
    chk("t6_fault", p0Fault, 1);
    chk("t6_latency", last_ack_cyc - strobe_cyc, TO + 2);

    // Inputs changed mid-transaction are ignored
    resp_delay = 5; resp_status = MC_DONE;
    sb = strobe_cnt;
    @(negedge clk);
    p0Req = 1; p0Addr = 32'h10;
    wait_strobe(10);
    repeat (2) @(negedge clk);
    p0Addr = 32'h44; p1Req = 1; p1Addr = 32'h0; p1Write = 0;
    @(negedge clk);
    chk("t7_addr_held", mcRamAddress, 32'h10);
    wait_ack(0, 20);
    chk("t7_rdata", p0RData, 32'hDEAD_BEEF);
    chk("t7_strobes", strobe_cnt - sb, 1);
    wait_ack(1, 20);
    chk("t7_p1_rdata", p1RData, 32'h0000_0123);

    // Asynchronous reset during WAIT, then a pending port 1 request is served
    resp_delay = 6;
    @(negedge clk);
    p0Req = 1; p0Addr = 32'h10;
    wait_strobe(10);
    repeat (3) @(negedge clk);
    p1Req = 1; p1Addr = 32'h0;
    #2;
    reset = 1;
    #1;
    chk("t8_busy", busy, 0);
    chk("t8_addr", mcRamAddress, 0);
    chk("t8_p0rdata", p0RData, 0);
    chk("t8_p1rdata", p1RData, 0);
    chk("t8_p0ack", p0Ack, 0);
    a1b = ack_cnt[0];
    @(negedge clk);
    p0Req = 0;
    @(negedge clk);
    reset = 0;
    resp_delay = 2;
    wait_ack(1, 20);
    chk("t8_p1_rdata", p1RData, 32'h0000_0123);
    chk("t8_p1_fault", p1Fault, 0);
    chk("t8_p0_acks", ack_cnt[0] - a1b, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
